lcd_hex_driver: RTL and testbench
=================================

Name: lcd_hex_driver

Overview:
Consumes the two 16-bit words from lcd_data_gen (line1, line2) and drives a 16x2 HD44780-compatible character LCD over its 8-bit parallel bus. It shows each word as 4 uppercase hex digits, line1 on row 1 and line2 on row 2, at columns 0-3. After the power-up init sequence it refreshes the display continuously. Sits between lcd_data_gen and the LCD pins on the FPGA board.

Parameters:
POWERUP_CYC, 750000, clk cycles of idle after reset before the first command (15 ms @ 50 MHz)
SETUP_CYC, 2, cycles lcd_data/lcd_rs are stable before lcd_en rises
EN_CYC, 25, cycles lcd_en is held high per byte
CMD_CYC, 2500, cycles of lcd_en-low wait after any byte except clear (50 us)
CLR_CYC, 100000, cycles of lcd_en-low wait after the clear command 0x01 (2 ms)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
line1  in  16  word for row 1, from lcd_data_gen
line2  in  16  word for row 2, from lcd_data_gen
lcd_data  out  8  LCD data/command bus
lcd_rs  out  1  0 = command, 1 = character data
lcd_rw  out  1  tied 0 (write only)
lcd_en  out  1  LCD enable strobe
lcd_on  out  1  LCD power enable
frame_done  out  1  one-cycle pulse after the last character of each frame

Behaviour:
- Reset (async, reset_n=0): lcd_data=0, lcd_rs=0, lcd_rw=0, lcd_en=0, lcd_on=0, frame_done=0. All counters and states return to PWR_WAIT. A reset mid-byte drops lcd_en immediately.
- lcd_on=1 from the first clock edge after reset_n rises. lcd_rw stays 0 at all times.
- Byte write, repeated for every byte:
  - start accepted at edge t: lcd_data/lcd_rs are driven from t+1 and held until the next start.
  - lcd_en=0 for SETUP_CYC cycles, then 1 for exactly EN_CYC cycles, then 0 for WAIT cycles (CLR_CYC if the byte is command 0x01, else CMD_CYC).
  - done pulses in the last wait cycle. The controller issues the next start on the following edge.
  - The byte period is therefore SETUP_CYC+EN_CYC+WAIT cycles plus 1 issue cycle.
- Controller states:
  - PWR_WAIT: counts POWERUP_CYC cycles with lcd_en=0, then goes to INIT.
  - INIT: writes commands with rs=0, in order 0x38 (8-bit, 2-line), 0x0C (display on, no cursor), 0x01 (clear), 0x06 (entry increment). Then goes to FRAME.
  - FRAME: on entry, snapshots line1/line2 into internal registers. It then writes 10 bytes in order: 0x80 (rs=0); hex of line1 bits [15:12],[11:8],[7:4],[3:0] (rs=1); 0xC0 (rs=0); the same 4 digits for line2 (rs=1).
  - After the 10th byte's done, frame_done pulses for 1 cycle and FRAME restarts with a new snapshot. INIT never recurs without reset.
- Hex encoding: nibble 0-9 -> 0x30+n; nibble 10-15 -> 0x41+(n-10). Uppercase only.
- Input changes mid-frame do not affect the current frame. They appear in the next frame.
- Counters must be wide enough for the largest of the parameters. Wrap-around is not permitted: counters reset at each phase.

Decomposition:
- Package lcd_pkg holds:
  - command constants: CMD_FUNC_SET=0x38, CMD_DISP_ON=0x0C, CMD_CLEAR=0x01, CMD_ENTRY=0x06, ADDR_ROW1=0x80, ADDR_ROW2=0xC0;
  - the controller state enum (PWR_WAIT, INIT, FRAME);
  - the nibble-to-ASCII function.
- One sub-module, lcd_byte_writer:
  - ports: start, data[7:0], rs, long_wait -> lcd_data, lcd_rs, lcd_en, done;
  - owns SETUP/EN/WAIT timing with internal states IDLE, SETUP, EN_HI, HOLD.
- lcd_hex_driver owns sequencing, snapshots and hex conversion.

Test Plan:
All tests use POWERUP_CYC=20, SETUP_CYC=2, EN_CYC=3, CMD_CYC=10, CLR_CYC=40, and a bench monitor that captures {rs,data} on each lcd_en falling edge.
- Power-up and init: release reset_n -> lcd_on=1 next edge; lcd_en stays 0 for 20 cycles; captured bytes are {0,0x38},{0,0x0C},{0,0x01},{0,0x06}.
- Frame content: line1=16'hACAD, line2=16'hDAF2 -> next 10 captures are {0,0x80},{1,0x41},{1,0x43},{1,0x41},{1,0x44},{0,0xC0},{1,0x44},{1,0x41},{1,0x46},{1,0x32}; frame_done pulses once for 1 cycle.
- Snapshot: change line1 to 16'h0129 during byte 3 of a frame -> that frame still shows "ACAD"; the next frame shows 0x30,0x31,0x32,0x39.
- Timing: every lcd_en pulse is exactly 3 cycles high; lcd_data/lcd_rs are stable from ≥2 cycles before the rise until the next start; the gap after 0x01 is ≥40 cycles and after other bytes ≥10 cycles.
- Nibble boundaries: line1=16'h9AF0 -> chars 0x39,0x41,0x46,0x30.
- Reset mid-operation: assert reset_n=0 while lcd_en=1 -> lcd_en and lcd_on go to 0 in the same cycle without a clock edge; after release, the 20-cycle wait and full INIT sequence repeat.

Source files
------------

// File: rtl/lcd_pkg.sv
// ---------------------------------------------------------------------------
// lcd_pkg
// Shared definitions for the HD44780 hex display driver: the command bytes
// sent to the panel, the controller and byte-writer state types, and the
// nibble-to-ASCII conversion used when building character bytes.
// No ports (package).
// ---------------------------------------------------------------------------
package lcd_pkg;

    localparam logic [7:0] CMD_FUNC_SET = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
    localparam logic [7:0] CMD_DISP_ON  = 8'h0C;  // display on, cursor off
    localparam logic [7:0] CMD_CLEAR    = 8'h01;  // clear display (slow command)
    localparam logic [7:0] CMD_ENTRY    = 8'h06;  // auto-increment address
    localparam logic [7:0] ADDR_ROW1    = 8'h80;  // DDRAM address 0x00
    localparam logic [7:0] ADDR_ROW2    = 8'hC0;  // DDRAM address 0x40

    typedef enum logic [1:0] {
        PWR_WAIT,
        INIT,
        FRAME
    } ctrl_state_e;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        EN_HI,
        HOLD
    } wr_state_e;

    // Uppercase hex digit: 0-9 map to '0'-'9', 10-15 map to 'A'-'F'.
    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
        logic [7:0] n8;
        n8 = {4'h0, nib};
        if (nib < 4'd10) begin
            return 8'h30 + n8;
        end
        return 8'h37 + n8;
    endfunction

endpackage

// File: rtl/lcd_hex_driver_if.sv
// ---------------------------------------------------------------------------
// lcd_hex_driver_if
// Pin-level bundle of the HD44780 parallel interface.
//   lcd_data[7:0] : data/command bus
//   lcd_rs        : 0 = command, 1 = character data
//   lcd_rw        : read/write select (always write here)
//   lcd_en        : enable strobe
//   lcd_on        : panel power enable
// master: the driver (drives every pin); slave: the panel / observer.
// ---------------------------------------------------------------------------
interface lcd_hex_driver_if;

    logic [7:0] lcd_data;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_en;
    logic       lcd_on;

    modport master (
        output lcd_data,
        output lcd_rs,
        output lcd_rw,
        output lcd_en,
        output lcd_on
    );

    modport slave (
        input lcd_data,
        input lcd_rs,
        input lcd_rw,
        input lcd_en,
        input lcd_on
    );

endinterface

// File: rtl/lcd_byte_writer.sv
// ---------------------------------------------------------------------------
// lcd_byte_writer
// Writes one byte to the LCD bus with HD44780 timing. A start seen while idle
// latches data/rs, which then stay on the bus until the next start. The
// enable strobe is low for SETUP_CYC cycles, high for EN_CYC cycles, then low
// for CMD_CYC (or CLR_CYC when long_wait) cycles; done pulses in the final
// wait cycle.
// Ports:
//   clk, reset_n        : clock, asynchronous active-low reset
//   start               : begin a byte (honoured only when idle)
//   data[7:0], rs       : byte and register select to send
//   long_wait           : use the long post-write wait (clear command)
//   lcd_data, lcd_rs    : held bus value
//   lcd_en              : enable strobe
//   done                : one-cycle pulse at the end of the byte period
// ---------------------------------------------------------------------------
module lcd_byte_writer
    import lcd_pkg::*;
#(
    parameter int SETUP_CYC = 2,
    parameter int EN_CYC    = 25,
    parameter int CMD_CYC   = 2500,
    parameter int CLR_CYC   = 100000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [7:0] data,
    input  logic       rs,
    input  logic       long_wait,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_en,
    output logic       done
);

    localparam int MAX_AB  = (SETUP_CYC > EN_CYC) ? SETUP_CYC : EN_CYC;
    localparam int MAX_CD  = (CMD_CYC > CLR_CYC) ? CMD_CYC : CLR_CYC;
    localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    wr_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       data_q, data_d;
    logic             rs_q, rs_d;
    logic             long_q, long_d;
    logic [CNT_W-1:0] wait_last;

    assign wait_last = long_q ? CNT_W'(CLR_CYC - 1) : CNT_W'(CMD_CYC - 1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= 8'h00;
            rs_q    <= 1'b0;
            long_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            rs_q    <= rs_d;
            long_q  <= long_d;
        end
    end

    // Each phase restarts its counter from zero so no count ever wraps.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        rs_d    = rs_q;
        long_d  = long_q;
        lcd_en  = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    data_d  = data;
                    rs_d    = rs;
                    long_d  = long_wait;
                    cnt_d   = '0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (cnt_q == CNT_W'(SETUP_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = EN_HI;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            EN_HI: begin
                lcd_en = 1'b1;
                if (cnt_q == CNT_W'(EN_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (cnt_q == wait_last) begin
                    done    = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign lcd_data = data_q;
    assign lcd_rs   = rs_q;

endmodule

// File: rtl/lcd_hex_driver.sv
// ---------------------------------------------------------------------------
// lcd_hex_driver
// Shows two 16-bit words as 4 uppercase hex digits each on a 16x2 HD44780
// LCD (line1 on row 1, line2 on row 2, columns 0-3). After a power-up delay
// it sends the init command sequence once, then refreshes the display
// forever, snapshotting both words at the start of every frame.
// Ports:
//   clk, reset_n  : clock, asynchronous active-low reset
//   line1, line2  : words to display
//   lcd           : LCD pin bundle (master side)
//   frame_done    : one-cycle pulse after the last character of a frame
// ---------------------------------------------------------------------------
module lcd_hex_driver
    import lcd_pkg::*;
#(
    parameter int POWERUP_CYC = 750000,
    parameter int SETUP_CYC   = 2,
    parameter int EN_CYC      = 25,
    parameter int CMD_CYC     = 2500,
    parameter int CLR_CYC     = 100000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [15:0]         line1,
    input  logic [15:0]         line2,
    lcd_hex_driver_if.master    lcd,
    output logic                frame_done
);

    localparam int PWR_W = $clog2(POWERUP_CYC + 1);

    ctrl_state_e      state_q, state_d;
    logic [PWR_W-1:0] pwr_cnt_q, pwr_cnt_d;
    logic [3:0]       idx_q, idx_d;
    logic             issue_q, issue_d;
    logic [15:0]      snap1_q, snap1_d;
    logic [15:0]      snap2_q, snap2_d;
    logic             frame_done_q, frame_done_d;
    logic             lcd_on_q, lcd_on_d;

    logic [7:0]       byte_data;
    logic             byte_rs;
    logic             long_wait;
    logic             wr_done;
    logic [7:0]       wr_data;
    logic             wr_rs;
    logic             wr_en;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= PWR_WAIT;
            pwr_cnt_q    <= '0;
            idx_q        <= 4'd0;
            issue_q      <= 1'b0;
            snap1_q      <= 16'h0000;
            snap2_q      <= 16'h0000;
            frame_done_q <= 1'b0;
            lcd_on_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            pwr_cnt_q    <= pwr_cnt_d;
            idx_q        <= idx_d;
            issue_q      <= issue_d;
            snap1_q      <= snap1_d;
            snap2_q      <= snap2_d;
            frame_done_q <= frame_done_d;
            lcd_on_q     <= lcd_on_d;
        end
    end

    // Sequencer: issue_q is a one-cycle start pulse raised on the edge after
    // the writer's done, so the selected byte below is already updated (index
    // and snapshot) when the writer latches it.
    always_comb begin
        state_d      = state_q;
        pwr_cnt_d    = pwr_cnt_q;
        idx_d        = idx_q;
        issue_d      = 1'b0;
        snap1_d      = snap1_q;
        snap2_d      = snap2_q;
        frame_done_d = 1'b0;
        lcd_on_d     = 1'b1;
        case (state_q)
            PWR_WAIT: begin
                if (pwr_cnt_q == PWR_W'(POWERUP_CYC - 1)) begin
                    pwr_cnt_d = '0;
                    idx_d     = 4'd0;
                    issue_d   = 1'b1;
                    state_d   = INIT;
                end else begin
                    pwr_cnt_d = pwr_cnt_q + 1'b1;
                end
            end
            INIT: begin
                if (wr_done) begin
                    issue_d = 1'b1;
                    if (idx_q == 4'd3) begin
                        idx_d   = 4'd0;
                        snap1_d = line1;
                        snap2_d = line2;
                        state_d = FRAME;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            FRAME: begin
                if (wr_done) begin
                    issue_d = 1'b1;
                    if (idx_q == 4'd9) begin
                        idx_d        = 4'd0;
                        snap1_d      = line1;
                        snap2_d      = line2;
                        frame_done_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d   = PWR_WAIT;
                pwr_cnt_d = '0;
                idx_d     = 4'd0;
            end
        endcase
    end

    // Byte selection: INIT walks the command table; FRAME sends the row 1
    // address, four digits of line1, the row 2 address, four digits of line2.
    always_comb begin
        byte_data = 8'h00;
        byte_rs   = 1'b0;
        case (state_q)
            INIT: begin
                case (idx_q)
                    4'd0:    byte_data = CMD_FUNC_SET;
                    4'd1:    byte_data = CMD_DISP_ON;
                    4'd2:    byte_data = CMD_CLEAR;
                    default: byte_data = CMD_ENTRY;
                endcase
            end
            FRAME: begin
                byte_rs = 1'b1;
                case (idx_q)
                    4'd0: begin
                        byte_data = ADDR_ROW1;
                        byte_rs   = 1'b0;
                    end
                    4'd1: byte_data = nibble_to_ascii(snap1_q[15:12]);
                    4'd2: byte_data = nibble_to_ascii(snap1_q[11:8]);
                    4'd3: byte_data = nibble_to_ascii(snap1_q[7:4]);
                    4'd4: byte_data = nibble_to_ascii(snap1_q[3:0]);
                    4'd5: begin
                        byte_data = ADDR_ROW2;
                        byte_rs   = 1'b0;
                    end
                    4'd6: byte_data = nibble_to_ascii(snap2_q[15:12]);
                    4'd7: byte_data = nibble_to_ascii(snap2_q[11:8]);
                    4'd8: byte_data = nibble_to_ascii(snap2_q[7:4]);
                    default: byte_data = nibble_to_ascii(snap2_q[3:0]);
                endcase
            end
            default: begin
                byte_data = 8'h00;
                byte_rs   = 1'b0;
            end
        endcase
    end

    // Characters never equal 0x01, but rs is checked so only the command waits long.
    assign long_wait = !byte_rs && (byte_data == CMD_CLEAR);

    lcd_byte_writer #(
        .SETUP_CYC (SETUP_CYC),
        .EN_CYC    (EN_CYC),
        .CMD_CYC   (CMD_CYC),
        .CLR_CYC   (CLR_CYC)
    ) u_writer (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (issue_q),
        .data      (byte_data),
        .rs        (byte_rs),
        .long_wait (long_wait),
        .lcd_data  (wr_data),
        .lcd_rs    (wr_rs),
        .lcd_en    (wr_en),
        .done      (wr_done)
    );

    assign lcd.lcd_data = wr_data;
    assign lcd.lcd_rs   = wr_rs;
    assign lcd.lcd_rw   = 1'b0;
    assign lcd.lcd_en   = wr_en;
    assign lcd.lcd_on   = lcd_on_q;
    assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_lcd_hex_driver.sv
// ---------------------------------------------------------------------------
// tb_lcd_hex_driver
// Scoreboard bench: stimulus pushes the expected {rs,data} byte stream into a
// queue; a monitor captures each byte on the lcd_en falling edge, pops and
// compares, and also checks strobe width, bus setup, post-write gaps and the
// frame_done pulse.
// ---------------------------------------------------------------------------
module tb_lcd_hex_driver;

    localparam int P_PWR = 20;
    localparam int P_SET = 2;
    localparam int P_EN  = 3;
    localparam int P_CMD = 10;
    localparam int P_CLR = 40;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] line1;
    logic [15:0] line2;
    logic        frame_done;

    lcd_hex_driver_if lcd ();

    lcd_hex_driver #(
        .POWERUP_CYC (P_PWR),
        .SETUP_CYC   (P_SET),
        .EN_CYC      (P_EN),
        .CMD_CYC     (P_CMD),
        .CLR_CYC     (P_CLR)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .line1      (line1),
        .line2      (line2),
        .lcd        (lcd),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [8:0] exp_q[$];
    int         cap_cnt     = 0;
    int         frames_seen = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkAtLeast(input string name, input int actual, input int minimum);
        n_checks++;
        if (actual < minimum) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected at least %0d", name, actual, minimum);
        end
    endtask

    // Reference model: the display content written as plain character arithmetic.
    function automatic logic [7:0] hexChar(input int n);
        if (n < 10) return 8'(48 + n);
        return 8'(65 + n - 10);
    endfunction

    task automatic pushInit();
        exp_q.push_back({1'b0, 8'h38});
        exp_q.push_back({1'b0, 8'h0C});
        exp_q.push_back({1'b0, 8'h01});
        exp_q.push_back({1'b0, 8'h06});
    endtask

    task automatic pushFrame(input int l1, input int l2);
        exp_q.push_back({1'b0, 8'h80});
        for (int i = 3; i >= 0; i--) exp_q.push_back({1'b1, hexChar((l1 >> (4 * i)) % 16)});
        exp_q.push_back({1'b0, 8'hC0});
        for (int i = 3; i >= 0; i--) exp_q.push_back({1'b1, hexChar((l2 >> (4 * i)) % 16)});
    endtask

    task automatic applyStimulus(input logic [15:0] l1, input logic [15:0] l2);
        line1 = l1;
        line2 = l2;
        pushFrame(int'(l1), int'(l2));
    endtask

    // Monitor: all sampling on the falling clock edge.
    logic [8:0] prev_bus = '0;
    logic       prev_en  = 1'b0;
    logic       fd_prev  = 1'b0;
    logic       have_prev = 1'b0;
    int         stable  = 0;
    int         hi_cnt  = 0;
    int         lo_cnt  = 0;
    int         req_gap = 0;

    always @(negedge clk) begin
        logic [8:0] cur;
        logic [8:0] e;
        cur = {lcd.lcd_rs, lcd.lcd_data};
        if (!reset_n) begin
            prev_bus    = '0;
            prev_en     = 1'b0;
            fd_prev     = 1'b0;
            have_prev   = 1'b0;
            stable      = 0;
            hi_cnt      = 0;
            lo_cnt      = 0;
            cap_cnt     = 0;
            frames_seen = 0;
        end else begin
            if (cur == prev_bus) stable++;
            else stable = 0;
            if (lcd.lcd_en && !prev_en) begin
                checkAtLeast("setup_before_rise", stable, P_SET);
                if (have_prev) checkAtLeast("gap_after_byte", lo_cnt, req_gap);
                checkOutput("lcd_rw", 32'(lcd.lcd_rw), 32'd0);
                checkOutput("lcd_on", 32'(lcd.lcd_on), 32'd1);
                hi_cnt = 1;
            end else if (lcd.lcd_en) begin
                hi_cnt++;
            end else if (prev_en) begin
                checkOutput("en_width", 32'(hi_cnt), 32'(P_EN));
                checkAtLeast("bus_held", stable, P_SET + P_EN);
                cap_cnt++;
                e = cur;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    checkOutput($sformatf("byte%0d", cap_cnt), 32'(cur), 32'(e));
                end
                req_gap   = (e == 9'h001) ? P_CLR : P_CMD;
                have_prev = 1'b1;
                lo_cnt    = 1;
            end else begin
                lo_cnt++;
            end
            if (frame_done) begin
                checkOutput("frame_done_width", 32'(fd_prev), 32'd0);
                checkOutput("frame_done_pos",
                            32'((cap_cnt > 4) && ((cap_cnt - 4) % 10 == 0)), 32'd1);
                frames_seen++;
            end
            prev_en = lcd.lcd_en;
            prev_bus = cur;
            fd_prev = frame_done;
        end
    end

    task automatic waitCaps(input int target);
        int n = 0;
        while (cap_cnt < target && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checkAtLeast("wait_captures", cap_cnt, target);
    endtask

    task automatic waitFrames(input int target);
        int n = 0;
        while (frames_seen < target && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checkAtLeast("wait_frames", frames_seen, target);
    endtask

    task automatic waitDrain();
        int n = 0;
        while (exp_q.size() > 0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic checkPowerUp();
        int n = 0;
        while (!lcd.lcd_en && n < 200) begin
            @(negedge clk);
            if (!lcd.lcd_en) n++;
        end
        checkAtLeast("powerup_quiet", n, P_PWR);
        checkOutput("powerup_en_seen", 32'(lcd.lcd_en), 32'd1);
    endtask

    initial begin
        int n;
        line1   = 16'hACAD;
        line2   = 16'hDAF2;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_lcd_en", 32'(lcd.lcd_en), 32'd0);
        checkOutput("reset_lcd_on", 32'(lcd.lcd_on), 32'd0);
        checkOutput("reset_lcd_data", 32'(lcd.lcd_data), 32'd0);
        checkOutput("reset_lcd_rs", 32'(lcd.lcd_rs), 32'd0);
        checkOutput("reset_lcd_rw", 32'(lcd.lcd_rw), 32'd0);
        checkOutput("reset_frame_done", 32'(frame_done), 32'd0);

        pushInit();
        pushFrame(16'hACAD, 16'hDAF2);
        @(negedge clk);
        reset_n = 1'b1;
        #1 checkOutput("lcd_on_before_edge", 32'(lcd.lcd_on), 32'd0);
        @(negedge clk);
        checkOutput("lcd_on_after_edge", 32'(lcd.lcd_on), 32'd1);
        checkPowerUp();

        // Change line1 while the third byte of the first frame is in flight.
        waitCaps(6);
        applyStimulus(16'h0129, 16'hDAF2);

        waitFrames(1);
        applyStimulus(16'h9AF0, 16'($urandom));
        for (int k = 2; k <= 6; k++) begin
            waitFrames(k);
            repeat ($urandom_range(0, 100)) @(negedge clk);
            applyStimulus(16'($urandom), 16'($urandom));
        end
        waitDrain();

        // Reset while the strobe is high must drop it without a clock edge.
        n = 0;
        while (!lcd.lcd_en && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("en_high_before_reset", 32'(lcd.lcd_en), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("async_reset_en", 32'(lcd.lcd_en), 32'd0);
        checkOutput("async_reset_on", 32'(lcd.lcd_on), 32'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        pushInit();
        pushFrame(int'(line1), int'(line2));
        reset_n = 1'b1;
        checkPowerUp();
        waitDrain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
